// File: rtl/collectible_anim_controller_if.sv
// Control and sprite-side signal bundle for the collectible animation controller.
// The master side is the level/collision logic; the slave side is the controller.
interface collectible_anim_controller_if #(
  parameter int NUM_SLOTS = 4,
  parameter int FRAME_W   = 4
);
  logic                           enable;
  logic [NUM_SLOTS-1:0]           spawn_mask;
  logic [NUM_SLOTS-1:0]           collect_req;
  logic [NUM_SLOTS-1:0]           slot_visible;
  logic [NUM_SLOTS*FRAME_W-1:0]   frame_sel;
  logic [NUM_SLOTS-1:0]           collect_ack;
  logic [7:0]                     collected;
  logic                           anim_tick;

  modport master (
    output enable, spawn_mask, collect_req,
    input  slot_visible, frame_sel, collect_ack, collected, anim_tick
  );

  modport slave (
    input  enable, spawn_mask, collect_req,
    output slot_visible, frame_sel, collect_ack, collected, anim_tick
  );
endinterface

// File: rtl/collectible_anim_controller.sv
// Sequences NUM_SLOTS collectibles through spawn, spin, sparkle and respawn wait,
// driven by one shared animation-tick prescaler; all outputs are registered.
module collectible_anim_controller #(
  parameter int NUM_SLOTS      = 4,
  parameter int TICK_DIV       = 6240000,
  parameter int SPIN_FRAMES    = 7,
  parameter int COLLECT_FRAMES = 4,
  parameter int RESPAWN_TICKS  = 64,
  parameter int FRAME_W        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  collectible_anim_controller_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RSP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS + 1) : 1;
  localparam int ACC_W = $clog2(NUM_SLOTS + 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_SPIN    = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(TICK_DIV - 1);
  localparam logic [FRAME_W-1:0] LAST_SPIN     = FRAME_W'(SPIN_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FIRST_SPARKLE = FRAME_W'(SPIN_FRAMES);
  localparam logic [FRAME_W-1:0] LAST_SPARKLE  = FRAME_W'(SPIN_FRAMES + COLLECT_FRAMES - 1);
  localparam logic [RSP_W-1:0]   RSP_INIT      = RSP_W'(RESPAWN_TICKS);

  // Prescaler
  logic [CNT_W-1:0] r_count;
  logic             w_tick;
  logic             r_anim_tick;

  assign w_tick = bus.enable && (r_count == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_anim_tick <= 1'b0;
    end else begin
      r_anim_tick <= w_tick;
      if (bus.enable) r_count <= w_tick ? '0 : r_count + CNT_W'(1);
    end
  end

  // Per-slot state
  logic [1:0]         r_state   [NUM_SLOTS];
  logic [FRAME_W-1:0] r_frame   [NUM_SLOTS];
  logic [RSP_W-1:0]   r_rsp     [NUM_SLOTS];
  logic [1:0]         w_state   [NUM_SLOTS];
  logic [FRAME_W-1:0] w_frame   [NUM_SLOTS];
  logic [RSP_W-1:0]   w_rsp     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_accept;
  logic [NUM_SLOTS-1:0] w_visible;
  logic [NUM_SLOTS-1:0] r_visible;
  logic [NUM_SLOTS-1:0] r_ack;

  // NOTE: every next-state variable is defaulted to its current value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_state[i]  = r_state[i];
      w_frame[i]  = r_frame[i];
      w_rsp[i]    = r_rsp[i];
      w_accept[i] = 1'b0;
      case (r_state[i])
        ST_EMPTY: begin
          if (bus.spawn_mask[i]) begin
            w_state[i] = ST_SPIN;
            w_frame[i] = '0;
          end
        end
        ST_SPIN: begin
          if (bus.collect_req[i]) begin
            w_state[i]  = ST_COLLECT;
            w_frame[i]  = FIRST_SPARKLE;
            w_accept[i] = 1'b1;
          end else if (w_tick) begin
            w_frame[i] = (r_frame[i] == LAST_SPIN) ? '0 : r_frame[i] + FRAME_W'(1);
          end
        end
        ST_COLLECT: begin
          if (w_tick) begin
            if (r_frame[i] == LAST_SPARKLE) begin
              w_state[i] = (RESPAWN_TICKS == 0) ? ST_EMPTY : ST_WAIT;
              w_frame[i] = '0;
              w_rsp[i]   = RSP_INIT;
            end else begin
              w_frame[i] = r_frame[i] + FRAME_W'(1);
            end
          end
        end
        default: begin // ST_WAIT
          if (bus.spawn_mask[i] || (w_tick && r_rsp[i] == RSP_W'(1))) begin
            w_state[i] = ST_SPIN;
            w_frame[i] = '0;
          end else if (w_tick) begin
            w_rsp[i] = r_rsp[i] - RSP_W'(1);
          end
        end
      endcase
      w_visible[i] = (w_state[i] == ST_SPIN) || (w_state[i] == ST_COLLECT);
    end
  end

  // NOTE: the per-slot arrays are a handful of flops, so they are reset like any
  // other register; this guarantees invisible, frame-0 slots straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= ST_EMPTY;
        r_frame[i] <= '0;
        r_rsp[i]   <= '0;
      end
      r_visible <= '0;
      r_ack     <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= w_state[i];
        r_frame[i] <= w_frame[i];
        r_rsp[i]   <= w_rsp[i];
      end
      r_visible <= w_visible;
      r_ack     <= w_accept;
    end
  end

  // Shared saturating collect count
  logic [ACC_W-1:0] w_n_acc;
  logic [15:0]      w_sum;
  logic [7:0]       r_collected;

  always_comb begin
    w_n_acc = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_n_acc = w_n_acc + ACC_W'(w_accept[i]);
    w_sum = 16'(r_collected) + 16'(w_n_acc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_collected <= '0;
    else        r_collected <= (w_sum > 16'd255) ? 8'hFF : w_sum[7:0];
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_frame_out
    assign bus.frame_sel[g*FRAME_W +: FRAME_W] = r_frame[g];
  end

  assign bus.slot_visible = r_visible;
  assign bus.collect_ack  = r_ack;
  assign bus.collected    = r_collected;
  assign bus.anim_tick    = r_anim_tick;

endmodule

// File: tb/tb_collectible_anim_controller.sv
// Directed bench for collectible_anim_controller with TICK_DIV=4, RESPAWN_TICKS=2.
module tb_collectible_anim_controller;
  localparam int NS = 4;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  collectible_anim_controller_if #(.NUM_SLOTS(NS), .FRAME_W(FW)) bus ();

  collectible_anim_controller #(
    .NUM_SLOTS(NS), .TICK_DIV(4), .SPIN_FRAMES(7), .COLLECT_FRAMES(4),
    .RESPAWN_TICKS(2), .FRAME_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the cycle right after an animation tick; bounded.
  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (bus.anim_tick) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s tick_timeout: no anim_tick within 8 cycles", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.spawn_mask = '0;
    bus.collect_req = '0;
    step(); step();
    n_vec++;
    if ({bus.slot_visible, bus.frame_sel, bus.collect_ack, bus.collected, bus.anim_tick} !== '0) begin
      n_err++;
      $display("FAIL reset_state: vis=%b frame=%h ack=%b coll=%0d tick=%b, want all 0",
               bus.slot_visible, bus.frame_sel, bus.collect_ack, bus.collected, bus.anim_tick);
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_vec++;
      if (bus.anim_tick !== (i % 4 == 3) ||
          {bus.slot_visible, bus.frame_sel, bus.collect_ack, bus.collected} !== '0) begin
        n_err++;
        $display("FAIL idle_tick cyc=%0d: tick=%b vis=%b frame=%h coll=%0d, want tick=%b rest 0",
                 i, bus.anim_tick, bus.slot_visible, bus.frame_sel, bus.collected, (i % 4 == 3));
      end
    end
  endtask

  task automatic test_spin();
    bus.spawn_mask = 4'b0001;
    step();
    bus.spawn_mask = '0;
    n_vec++;
    if (bus.slot_visible !== 4'b0001 || bus.frame_sel !== 16'h0000) begin
      n_err++;
      $display("FAIL spawn0: vis=%b frame=%h, want 0001 0000", bus.slot_visible, bus.frame_sel);
    end
    for (int k = 1; k <= 7; k++) begin
      wait_tick("spin");
      n_vec++;
      if (bus.frame_sel !== 16'(k % 7) || bus.slot_visible !== 4'b0001) begin
        n_err++;
        $display("FAIL spin_step k=%0d: frame=%h vis=%b, want %h 0001",
                 k, bus.frame_sel, bus.slot_visible, 16'(k % 7));
      end
    end
  endtask

  task automatic test_collect();
    repeat (3) wait_tick("pre_collect");
    bus.collect_req = 4'b0001;
    step();
    bus.collect_req = '0;
    n_vec++;
    if (bus.frame_sel !== 16'h0007 || bus.collect_ack !== 4'b0001 ||
        bus.collected !== 8'd1 || bus.slot_visible !== 4'b0001) begin
      n_err++;
      $display("FAIL collect_accept: frame=%h ack=%b coll=%0d vis=%b, want 0007 0001 1 0001",
               bus.frame_sel, bus.collect_ack, bus.collected, bus.slot_visible);
    end
    step();
    n_vec++;
    if (bus.collect_ack !== 4'b0000 || bus.collected !== 8'd1) begin
      n_err++;
      $display("FAIL ack_pulse: ack=%b coll=%0d, want 0000 1", bus.collect_ack, bus.collected);
    end
    for (int k = 8; k <= 10; k++) begin
      wait_tick("sparkle");
      n_vec++;
      if (bus.frame_sel !== 16'(k) || bus.slot_visible !== 4'b0001) begin
        n_err++;
        $display("FAIL sparkle k=%0d: frame=%h vis=%b", k, bus.frame_sel, bus.slot_visible);
      end
    end
    for (int k = 0; k < 3; k++) begin
      wait_tick("respawn");
      n_vec++;
      if (bus.slot_visible !== ((k == 2) ? 4'b0001 : 4'b0000) || bus.frame_sel !== 16'h0000) begin
        n_err++;
        $display("FAIL respawn k=%0d: vis=%b frame=%h, want vis=%b frame 0000",
                 k, bus.slot_visible, bus.frame_sel, (k == 2) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_multi_collect();
    logic [15:0] exp_frames [4];
    exp_frames = '{16'h2888, 16'h3999, 16'h4AAA, 16'h5000};
    bus.spawn_mask = 4'b1111;
    step();
    bus.spawn_mask = '0;
    n_vec++;
    if (bus.slot_visible !== 4'b1111 || bus.frame_sel !== 16'h0000) begin
      n_err++;
      $display("FAIL spawn_all: vis=%b frame=%h", bus.slot_visible, bus.frame_sel);
    end
    step(); step();
    bus.collect_req = 4'b0111;
    step();
    n_vec++;
    if (bus.frame_sel !== 16'h1777 || bus.collect_ack !== 4'b0111 ||
        bus.collected !== 8'd4 || bus.anim_tick !== 1'b1) begin
      n_err++;
      $display("FAIL multi_collect_tick: frame=%h ack=%b coll=%0d tick=%b, want 1777 0111 4 1",
               bus.frame_sel, bus.collect_ack, bus.collected, bus.anim_tick);
    end
    step();
    bus.collect_req = '0;
    n_vec++;
    if (bus.collect_ack !== 4'b0000 || bus.collected !== 8'd4 || bus.frame_sel !== 16'h1777) begin
      n_err++;
      $display("FAIL collect_in_collect: ack=%b coll=%0d frame=%h, want 0000 4 1777",
               bus.collect_ack, bus.collected, bus.frame_sel);
    end
    for (int k = 0; k < 4; k++) begin
      wait_tick("multi_sparkle");
      n_vec++;
      if (bus.frame_sel !== exp_frames[k]) begin
        n_err++;
        $display("FAIL multi_sparkle k=%0d: frame=%h, want %h", k, bus.frame_sel, exp_frames[k]);
      end
    end
    n_vec++;
    if (bus.slot_visible !== 4'b1000) begin
      n_err++;
      $display("FAIL wait_invisible: vis=%b, want 1000", bus.slot_visible);
    end
    bus.collect_req = 4'b0111;
    step();
    bus.collect_req = '0;
    n_vec++;
    if (bus.collect_ack !== 4'b0000 || bus.collected !== 8'd4) begin
      n_err++;
      $display("FAIL collect_in_wait: ack=%b coll=%0d, want 0000 4", bus.collect_ack, bus.collected);
    end
    bus.spawn_mask = 4'b1001;
    step();
    bus.spawn_mask = '0;
    n_vec++;
    if (bus.slot_visible !== 4'b1001 || bus.frame_sel !== 16'h5000) begin
      n_err++;
      $display("FAIL spawn_wait_and_spin: vis=%b frame=%h, want 1001 5000",
               bus.slot_visible, bus.frame_sel);
    end
  endtask

  task automatic test_saturate();
    int exp_coll = 4;
    for (int r = 0; r < 65; r++) begin
      bus.spawn_mask = 4'b1111;
      step();
      bus.spawn_mask = '0;
      bus.collect_req = 4'b1111;
      step();
      bus.collect_req = '0;
      exp_coll = (exp_coll + 4 > 255) ? 255 : exp_coll + 4;
      n_vec++;
      if (bus.collect_ack !== 4'b1111 || bus.collected !== 8'(exp_coll)) begin
        n_err++;
        $display("FAIL saturate r=%0d: ack=%b coll=%0d, want 1111 %0d",
                 r, bus.collect_ack, bus.collected, exp_coll);
      end
      repeat (4) wait_tick("saturate");
    end
    n_vec++;
    if (bus.collected !== 8'd255 || bus.slot_visible !== 4'b0000) begin
      n_err++;
      $display("FAIL saturate_hold: coll=%0d vis=%b, want 255 0000", bus.collected, bus.slot_visible);
    end
  endtask

  task automatic test_freeze_and_reset();
    bus.spawn_mask = 4'b0001;
    step();
    bus.spawn_mask = '0;
    bus.collect_req = 4'b0001;
    step();
    bus.collect_req = '0;
    n_vec++;
    if (bus.collect_ack !== 4'b0001 || bus.collected !== 8'd255 || bus.frame_sel !== 16'h0007) begin
      n_err++;
      $display("FAIL collect_at_255: ack=%b coll=%0d frame=%h, want 0001 255 0007",
               bus.collect_ack, bus.collected, bus.frame_sel);
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_vec++;
      if (bus.anim_tick !== 1'b0 || bus.frame_sel !== 16'h0007 || bus.slot_visible !== 4'b0001) begin
        n_err++;
        $display("FAIL freeze cyc=%0d: tick=%b frame=%h vis=%b, want 0 0007 0001",
                 i, bus.anim_tick, bus.frame_sel, bus.slot_visible);
      end
    end
    bus.enable = 1'b1;
    step();
    n_vec++;
    if (bus.anim_tick !== 1'b0 || bus.frame_sel !== 16'h0007) begin
      n_err++;
      $display("FAIL resume_hold: tick=%b frame=%h, want 0 0007", bus.anim_tick, bus.frame_sel);
    end
    step();
    n_vec++;
    if (bus.anim_tick !== 1'b1 || bus.frame_sel !== 16'h0008) begin
      n_err++;
      $display("FAIL resume_tick: tick=%b frame=%h, want 1 0008", bus.anim_tick, bus.frame_sel);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.slot_visible, bus.frame_sel, bus.collect_ack, bus.collected, bus.anim_tick} !== '0) begin
      n_err++;
      $display("FAIL async_reset: vis=%b frame=%h ack=%b coll=%0d tick=%b, want all 0",
               bus.slot_visible, bus.frame_sel, bus.collect_ack, bus.collected, bus.anim_tick);
    end
    step();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_spin();
    test_collect();
    test_multi_collect();
    test_saturate();
    test_freeze_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
